instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream fetch/dispatch controller for the microcontroller's per-opcode execution FSMs, including the MOV FSM.
- Maintains the PC and reads program memory at the PC.
- Latches the 16-bit word into an instruction register and presents it on `instruction` until the executing FSM reports `done`.
- Between instructions it drives NOP (16'h0000) for at least one cycle, so every opcode-gated FSM returns to its idle state.

Parameters:
- PC_WIDTH, 8, program-counter and memory-address width.
- INSTR_WIDTH, 16, instruction word width; opcode is bits [INSTR_WIDTH-1 -: 4].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  start fetching from IDLE; level-sensitive.
- mem_rd  output  1  program-memory read strobe.
- mem_addr  output  PC_WIDTH  program-memory address; equals pc.
- mem_data  input  INSTR_WIDTH  read data, valid exactly one cycle after mem_rd.
- pc_inc  input  1  OR of the exec FSMs' pcInc outputs; PC += 1.
- pc_load  input  1  branch request from jump FSMs.
- pc_load_val  input  PC_WIDTH  branch target.
- exec_done  input  1  OR of the exec FSMs' done outputs.
- instruction  output  INSTR_WIDTH  word broadcast to all exec FSMs.
- pc  output  PC_WIDTH  current program counter.
- halted  output  1  HALT opcode reached.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state=IDLE, pc=0, IR=0.
  - instruction=16'h0000, mem_rd=0, halted=0.
  - Reset mid-operation discards any in-flight fetch.
- States and transitions:
  - IDLE: instruction=0. run=1 -> FETCH; else stay.
  - FETCH: mem_rd=1, mem_addr=pc, instruction=0. Always -> WAIT.
  - WAIT: mem_rd=0. IR<=mem_data at the end of the cycle. -> DECODE.
  - DECODE: instruction=0.
    - IR opcode == OP_HALT -> HALTED.
    - IR opcode == OP_NOP -> pc<=pc+1, -> FETCH.
    - Otherwise -> EXEC.
  - EXEC: instruction=IR. exec_done=1 -> CLEAR; else stay.
  - CLEAR: instruction=0 for exactly one cycle, then -> FETCH.
  - HALTED: halted=1, instruction=0. Held until rst; run is ignored.
- PC rules:
  - pc_load has priority over pc_inc: pc<=pc_load_val.
  - pc_inc: pc<=pc+1, modulo 2^PC_WIDTH, so the top address wraps to 0.
  - Both are honoured only in EXEC; in other states they are ignored.
  - pc_inc is a level input; each high cycle adds 1.
- Timing:
  - pc_inc and exec_done in the same cycle: both take effect. The PC update completes before the FETCH two cycles later.
  - exec_done outside EXEC is ignored.
- Latency:
  - Minimum 4 cycles overhead per instruction: FETCH, WAIT, DECODE, CLEAR.
  - instruction changes only on state transitions, which makes it glitch-free for downstream level-decoded FSMs.
- Outputs are registered, except mem_addr, which is wired to pc.

Optional Feature:
- Macro: FETCH_WATCHDOG_EN.
- Defined:
  - Parameter WDT_CYCLES (default 64) is added.
  - An EXEC cycle counter is added; it clears on entry to EXEC.
  - If the counter reaches WDT_CYCLES without exec_done:
    - A sticky output `exec_err` (1 bit, reset 0) is set.
    - The FSM goes to CLEAR.
    - pc<=pc+1, skipping the instruction.
- Not defined: no counter and no exec_err port; EXEC waits indefinitely.

Decomposition:
- Package `mcu_pkg`:
  - Opcode constants OP_NOP=4'h0, OP_MOV=4'h4, OP_HALT=4'hF.
  - Fetch state encoding: IDLE, FETCH, WAIT, DECODE, EXEC, CLEAR, HALTED, 3-bit.
  - Shared by all exec FSMs.
- Sub-module `pc_counter`:
  - Inputs: clk, rst, load, load_val, inc, enable.
  - Output: pc, with wrap and load priority.
  - Reusable by a future call/return stack.

Test Plan:
- Reset, run=1, mem[0]=16'h4042 (MOV r1<-r2), exec FSM pulses pc_inc then done -> mem_rd at cycle 1 with addr 0. instruction=16'h4042 from cycle 4 until done. Then one cycle of 16'h0000; next fetch at addr 1.
- mem[0]=16'h0000 (NOP), mem[1]=16'hF000 -> pc goes 0->1 without EXEC. halted=1 and stays high; further run pulses and a spurious pc_inc leave pc=1.
- pc=8'hFF, MOV with pc_inc -> pc wraps to 8'h00; next fetch addr 0.
- In EXEC, pc_inc=1 and pc_load=1 with pc_load_val=8'h20 in the same cycle -> pc=8'h20, not pc+1.
- rst asserted during WAIT -> next cycle state=IDLE, pc=0, instruction=0; the captured mem_data is discarded.
- FETCH_WATCHDOG_EN, WDT_CYCLES=8, exec_done never asserted -> exec_err=1 after 8 EXEC cycles, CLEAR cycle follows, pc advances by 1, and the next fetch proceeds.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared opcode constants and fetch-state encoding for the fetch unit and the
// per-opcode execution FSMs.
package mcu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_CLEAR  = 3'd5,
        ST_HALTED = 3'd6
    } fetch_state_t;

    // True for opcodes that are consumed by the fetch unit itself and never
    // broadcast to the execution FSMs.
    function automatic logic is_fetch_local(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter with load-over-increment priority and natural wrap at the
// top of the address space; reusable by a future call/return stack.
module pc_counter #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_val,
    input  logic                inc,
    input  logic                enable,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] pc_next;

    always_comb begin
        pc_next = pc_reg;
        if (enable) begin
            if (load) begin
                pc_next = load_val;
            end else if (inc) begin
                pc_next = pc_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/dispatch controller: reads program memory at pc, holds the word on
// `instruction` until exec_done, and inserts NOP between instructions.
// Optional EXEC watchdog enabled by defining FETCH_WATCHDOG_EN.
module instr_fetch_unit
    import mcu_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
`ifdef FETCH_WATCHDOG_EN
    ,
    parameter int WDT_CYCLES  = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   mem_rd,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    input  logic                   pc_inc,
    input  logic                   pc_load,
    input  logic [PC_WIDTH-1:0]    pc_load_val,
    input  logic                   exec_done,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted
`ifdef FETCH_WATCHDOG_EN
    ,
    output logic                   exec_err
`endif
);

    fetch_state_t state_reg, state_next;

    logic [INSTR_WIDTH-1:0] ir_reg, ir_next;
    logic [INSTR_WIDTH-1:0] instruction_reg, instruction_next;
    logic                   mem_rd_reg, mem_rd_next;
    logic                   halted_reg, halted_next;

    logic                   pc_en;
    logic                   pc_inc_sel;
    logic                   pc_load_sel;
    logic [3:0]             opcode;

    assign opcode = ir_reg[INSTR_WIDTH-1 -: 4];

`ifdef FETCH_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt_reg;
    logic             exec_err_reg;
    logic             wdt_expired;

    assign wdt_expired = (wdt_cnt_reg == WDT_W'(WDT_CYCLES - 1));
`endif

    always_comb begin
        state_next  = state_reg;
        ir_next     = ir_reg;
        pc_en       = 1'b0;
        pc_inc_sel  = 1'b0;
        pc_load_sel = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                ir_next    = mem_data;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_next = ST_HALTED;
                end else if (opcode == OP_NOP) begin
                    // NOPs are retired here without ever reaching the exec FSMs
                    pc_en      = 1'b1;
                    pc_inc_sel = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pc_en       = 1'b1;
                pc_load_sel = pc_load;
                pc_inc_sel  = pc_inc;
                if (exec_done) begin
                    state_next = ST_CLEAR;
`ifdef FETCH_WATCHDOG_EN
                end else if (wdt_expired) begin
                    // Abandon the stuck instruction and step past it
                    pc_inc_sel = 1'b1;
                    state_next = ST_CLEAR;
`endif
                end
            end
            ST_CLEAR: begin
                state_next = ST_FETCH;
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they change only on state
    // transitions and come straight out of flops.
    always_comb begin
        mem_rd_next      = (state_next == ST_FETCH);
        halted_next      = (state_next == ST_HALTED);
        instruction_next = '0;
        if (state_next == ST_EXEC) begin
            instruction_next = ir_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            ir_reg          <= '0;
            instruction_reg <= '0;
            mem_rd_reg      <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ir_reg          <= ir_next;
            instruction_reg <= instruction_next;
            mem_rd_reg      <= mem_rd_next;
            halted_reg      <= halted_next;
        end
    end

`ifdef FETCH_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_reg  <= '0;
            exec_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_DECODE) begin
                wdt_cnt_reg <= '0;
            end else if (state_reg == ST_EXEC) begin
                wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
            end
            if (state_reg == ST_EXEC && !exec_done && wdt_expired) begin
                exec_err_reg <= 1'b1;
            end
        end
    end

    assign exec_err = exec_err_reg;
`endif

    pc_counter #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load_sel),
        .load_val (pc_load_val),
        .inc      (pc_inc_sel),
        .enable   (pc_en),
        .pc       (pc)
    );

    assign mem_addr    = pc;
    assign mem_rd      = mem_rd_reg;
    assign instruction = instruction_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random
// program interpreted by a program-level reference model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic        exec_done;
    logic [15:0] instruction;
    logic [7:0]  pc;
    logic        halted;
`ifdef FETCH_WATCHDOG_EN
    logic        exec_err;
`endif

    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (16)
`ifdef FETCH_WATCHDOG_EN
        ,
        .WDT_CYCLES  (8)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .exec_done   (exec_done),
        .instruction (instruction),
        .pc          (pc),
        .halted      (halted)
`ifdef FETCH_WATCHDOG_EN
        ,
        .exec_err    (exec_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program memory: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        run         = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 8'h00;
        exec_done   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_rd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_instr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instruction !== 16'h0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
        n_checks++; if (instruction !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", instruction); end
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
`ifdef FETCH_WATCHDOG_EN
        n_checks++; if (exec_err !== 1'b0) begin n_fail++; $display("FAIL reset_exec_err: got %b want 0", exec_err); end
`endif
        repeat (3) tick();
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL idle_no_run: mem_rd got %b want 0", mem_rd); end
        $display("test_reset done");
    endtask

    task automatic test_mov_timing();
        clear_mem();
        mem[0] = 16'h4042;
        mem[1] = 16'h4111;
        do_reset();
        run = 1'b1;
        tick();
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin n_fail++; $display("FAIL mov_fetch: rd=%b addr=%h want rd=1 addr=00", mem_rd, mem_addr); end
        tick();
        n_checks++; if (mem_rd !== 1'b0 || instruction !== 16'h0000) begin n_fail++; $display("FAIL mov_wait: rd=%b instr=%h want 0/0000", mem_rd, instruction); end
        tick();
        n_checks++; if (instruction !== 16'h0000) begin n_fail++; $display("FAIL mov_decode: instr=%h want 0000", instruction); end
        tick();
        n_checks++; if (instruction !== 16'h4042) begin n_fail++; $display("FAIL mov_exec_c4: instr=%h want 4042", instruction); end
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        n_checks++; if (pc !== 8'h01 || instruction !== 16'h4042) begin n_fail++; $display("FAIL mov_inc: pc=%h instr=%h want 01/4042", pc, instruction); end
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        n_checks++; if (instruction !== 16'h0000 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL mov_clear: instr=%h rd=%b want 0000/0", instruction, mem_rd); end
        tick();
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h01) begin n_fail++; $display("FAIL mov_next_fetch: rd=%b addr=%h want 1/01", mem_rd, mem_addr); end
        $display("test_mov_timing done");
    endtask

    task automatic test_nop_halt();
        logic [7:0] fetches [$];
        bit saw_exec;
        bit got_halt;
        clear_mem();
        mem[0] = 16'h0000;
        mem[1] = 16'hF000;
        do_reset();
        run = 1'b1;
        saw_exec = 1'b0;
        got_halt = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (mem_rd === 1'b1) fetches.push_back(mem_addr);
            if (instruction !== 16'h0000) saw_exec = 1'b1;
            if (halted === 1'b1) begin
                got_halt = 1'b1;
                break;
            end
        end
        n_checks++; if (!got_halt) begin n_fail++; $display("FAIL halt_reached: halted=%b want 1 within 30 cycles", halted); end
        n_checks++; if (saw_exec) begin n_fail++; $display("FAIL nop_no_exec: instruction broadcast seen, want none"); end
        n_checks++; if (fetches.size() != 2 || fetches[0] !== 8'h00 || fetches[1] !== 8'h01) begin n_fail++; $display("FAIL nop_fetch_seq: count=%0d want 2 fetches at 00,01", fetches.size()); end
        run = 1'b0; tick();
        run = 1'b1; tick();
        pc_inc = 1'b1; exec_done = 1'b1; tick(); tick();
        pc_inc = 1'b0; exec_done = 1'b0; run = 1'b0; tick();
        n_checks++; if (pc !== 8'h01) begin n_fail++; $display("FAIL halt_pc_hold: pc=%h want 01", pc); end
        n_checks++; if (halted !== 1'b1 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_sticky: halted=%b rd=%b want 1/0", halted, mem_rd); end
        $display("test_nop_halt done");
    endtask

    task automatic test_wrap();
        bit ok;
        clear_mem();
        mem[0]     = 16'h4042;
        mem[8'hFF] = 16'h4111;
        do_reset();
        run = 1'b1;
        wait_instr(ok);
        n_checks++; if (!ok || instruction !== 16'h4042) begin n_fail++; $display("FAIL wrap_first_exec: instr=%h want 4042", instruction); end
        pc_load = 1'b1; pc_load_val = 8'hFF; exec_done = 1'b1;
        tick();
        pc_load = 1'b0; exec_done = 1'b0;
        wait_fetch(ok);
        n_checks++; if (!ok || mem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_fetch_ff: addr=%h want ff", mem_addr); end
        wait_instr(ok);
        n_checks++; if (!ok || instruction !== 16'h4111) begin n_fail++; $display("FAIL wrap_exec_ff: instr=%h want 4111", instruction); end
        pc_inc = 1'b1; exec_done = 1'b1;
        tick();
        pc_inc = 1'b0; exec_done = 1'b0;
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: pc=%h want 00", pc); end
        wait_fetch(ok);
        n_checks++; if (!ok || mem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_fetch_0: addr=%h want 00", mem_addr); end
        $display("test_wrap done");
    endtask

    task automatic test_load_priority();
        bit ok;
        clear_mem();
        mem[0] = 16'h4042;
        do_reset();
        run = 1'b1;
        wait_instr(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL prio_exec: instr=%h want 4042", instruction); end
        pc_inc = 1'b1; pc_load = 1'b1; pc_load_val = 8'h20; exec_done = 1'b1;
        tick();
        pc_inc = 1'b0; pc_load = 1'b0; exec_done = 1'b0;
        n_checks++; if (pc !== 8'h20 || instruction !== 16'h0000) begin n_fail++; $display("FAIL prio_pc: pc=%h instr=%h want 20/0000", pc, instruction); end
        wait_fetch(ok);
        n_checks++; if (!ok || mem_addr !== 8'h20) begin n_fail++; $display("FAIL prio_fetch: addr=%h want 20", mem_addr); end
        $display("test_load_priority done");
    endtask

    task automatic test_reset_wait();
        bit ok;
        clear_mem();
        mem[0] = 16'h0000;
        mem[1] = 16'h4042;
        do_reset();
        run = 1'b1;
        wait_fetch(ok);
        wait_fetch(ok);
        n_checks++; if (!ok || mem_addr !== 8'h01) begin n_fail++; $display("FAIL rstw_fetch1: addr=%h want 01", mem_addr); end
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (pc !== 8'h00 || instruction !== 16'h0000 || mem_rd !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rstw_state: pc=%h instr=%h rd=%b halt=%b want 00/0000/0/0", pc, instruction, mem_rd, halted); end
        rst = 1'b0; run = 1'b0;
        repeat (4) tick();
        n_checks++; if (instruction !== 16'h0000 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL rstw_idle: instr=%h rd=%b want 0000/0", instruction, mem_rd); end
        run = 1'b1;
        wait_fetch(ok);
        n_checks++; if (!ok || mem_addr !== 8'h00) begin n_fail++; $display("FAIL rstw_refetch: addr=%h want 00", mem_addr); end
        $display("test_reset_wait done");
    endtask

    // Reference model: walk the program at instruction level, applying each
    // exec agent action to a model PC.
    task automatic test_random_program();
        bit          ok;
        logic [7:0]  pc_m;
        logic [15:0] word;
        logic [7:0]  target;
        int          k;
        bit          jump;
        bit          inc_last;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end
        do_reset();
        run  = 1'b1;
        pc_m = 8'h00;
        for (int s = 0; s < 40; s++) begin
            wait_fetch(ok);
            n_checks++; if (!ok || mem_addr !== pc_m) begin n_fail++; $display("FAIL rnd_fetch[%0d]: addr=%h want %h", s, mem_addr, pc_m); end
            word = mem[pc_m];
            if (word[15:12] == 4'h0) begin
                $display("step %0d: pc=%h NOP %h", s, pc_m, word);
                pc_m = pc_m + 8'h01;
                continue;
            end
            wait_instr(ok);
            n_checks++; if (!ok || instruction !== word) begin n_fail++; $display("FAIL rnd_instr[%0d]: instr=%h want %h", s, instruction, word); end
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                pc_inc = 1'b1;
                tick();
                n_checks++; if (instruction !== word) begin n_fail++; $display("FAIL rnd_hold[%0d]: instr=%h want %h", s, instruction, word); end
            end
            jump     = ($urandom_range(0, 3) == 0);
            target   = 8'($urandom);
            inc_last = 1'($urandom_range(0, 1));
            pc_inc = inc_last; pc_load = jump; pc_load_val = target; exec_done = 1'b1;
            tick();
            pc_inc = 1'b0; pc_load = 1'b0; exec_done = 1'b0;
            if (jump) pc_m = target;
            else      pc_m = pc_m + 8'(k) + 8'(inc_last);
            n_checks++; if (instruction !== 16'h0000 || pc !== pc_m) begin n_fail++; $display("FAIL rnd_clear[%0d]: instr=%h pc=%h want 0000/%h", s, instruction, pc, pc_m); end
            $display("step %0d: exec %h incs=%0d jump=%b next_pc=%h", s, word, k + int'(inc_last), jump, pc_m);
        end
        $display("test_random_program done");
    endtask

`ifdef FETCH_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        clear_mem();
        mem[0] = 16'h4042;
        mem[1] = 16'h4111;
        do_reset();
        run = 1'b1;
        wait_instr(ok);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (instruction !== 16'h4042 || exec_err !== 1'b0) begin n_fail++; $display("FAIL wdt_wait[%0d]: instr=%h err=%b want 4042/0", i, instruction, exec_err); end
            tick();
        end
        n_checks++; if (exec_err !== 1'b1 || instruction !== 16'h0000 || pc !== 8'h01) begin n_fail++; $display("FAIL wdt_fire: err=%b instr=%h pc=%h want 1/0000/01", exec_err, instruction, pc); end
        wait_fetch(ok);
        n_checks++; if (!ok || mem_addr !== 8'h01) begin n_fail++; $display("FAIL wdt_next_fetch: addr=%h want 01", mem_addr); end
        wait_instr(ok);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        n_checks++; if (exec_err !== 1'b1 || pc !== 8'h01) begin n_fail++; $display("FAIL wdt_sticky: err=%b pc=%h want 1/01", exec_err, pc); end
        $display("test_watchdog done");
    endtask
`endif

    initial begin
        rst = 1'b1; run = 1'b0; pc_inc = 1'b0; pc_load = 1'b0;
        pc_load_val = 8'h00; exec_done = 1'b0;
        test_reset();
        test_mov_timing();
        test_nop_halt();
        test_wrap();
        test_load_priority();
        test_reset_wait();
        test_random_program();
`ifdef FETCH_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
